// File: rtl/fault_injector.sv
// fault_injector: registers din to dout and, on request, corrupts one bit of the
// registered data (flip, stuck-at-0 or stuck-at-1) for a programmed window that
// starts after a programmed delay.
// Optional feature: define FAULT_INJECTOR_STATS_EN to count completed injections
// on inj_count (saturating); otherwise inj_count is tied to zero.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, and the request fields are captured on that edge.
module fault_injector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(WIDTH)-1:0] req_bit,
    input  logic [1:0]               req_mode,
    input  logic [CNT_W-1:0]         req_delay,
    input  logic [CNT_W-1:0]         req_dur,
    input  logic                     abort,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     active,
    output logic                     done,
    output logic [15:0]              inj_count,
    output logic [1:0]               dbg_state
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        INJECT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done_nxt;
    logic [BIT_W-1:0] bit_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] dur_q;
    logic             accept;
    logic             corrupt;
    logic [WIDTH-1:0] din_faulted;

    // A zero duration still injects for one cycle.
    function automatic logic [CNT_W-1:0] dur_eff(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_ONE : d;
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign active    = (state == INJECT);
    assign dbg_state = state;
    // Abort takes effect on the same edge it is seen, so that edge is already clean.
    assign corrupt   = (state == INJECT) && !abort;

    // State register, remaining-cycle counter and completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic: cnt holds the cycles left in the current WAIT or INJECT phase.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // abort is deliberately ignored here, even alongside a request.
                if (req_valid) begin
                    if (req_delay != '0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = req_delay;
                    end else begin
                        state_nxt = INJECT;
                        cnt_nxt   = dur_eff(req_dur);
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = INJECT;
                    cnt_nxt   = dur_eff(dur_q);
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            INJECT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request fields on acceptance; they stay fixed until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_q  <= '0;
            mode_q <= 2'b00;
            dur_q  <= '0;
        end else if (accept) begin
            bit_q  <= req_bit;
            mode_q <= req_mode;
            dur_q  <= req_dur;
        end
    end

    // Apply the selected fault to the target bit; mode 2'b11 behaves as a flip.
    always_comb begin
        din_faulted = din;
        case (mode_q)
            2'b01:   din_faulted[bit_q] = 1'b0;
            2'b10:   din_faulted[bit_q] = 1'b1;
            default: din_faulted[bit_q] = ~din[bit_q];
        endcase
    end

    // Output data register with one cycle of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else begin
            dout <= corrupt ? din_faulted : din;
        end
    end

`ifdef FAULT_INJECTOR_STATS_EN
    // Completed-injection counter, updated on the edge that raises done, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_count <= '0;
        end else if (done_nxt && (inj_count != 16'hFFFF)) begin
            inj_count <= inj_count + 16'd1;
        end
    end
`else
    assign inj_count = '0;
`endif

endmodule

// File: tb/tb_fault_injector.sv
// tb_fault_injector: directed scenarios plus randomized traffic for fault_injector,
// checked every cycle against a window-based model of the injection schedule.
module tb_fault_injector;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int BW    = $clog2(WIDTH);
`ifdef FAULT_INJECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [BW-1:0]    req_bit;
  logic [1:0]       req_mode;
  logic [CNT_W-1:0] req_delay;
  logic [CNT_W-1:0] req_dur;
  logic             abort;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             active;
  logic             done;
  logic [15:0]      inj_count;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit               din_rand  = 1'b1;
  logic [WIDTH-1:0] din_const = '0;

  fault_injector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_bit(req_bit), .req_mode(req_mode), .req_delay(req_delay), .req_dur(req_dur),
    .abort(abort), .din(din), .dout(dout), .active(active), .done(done),
    .inj_count(inj_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d, dut state %0d): got 'h%0h, expected 'h%0h",
               name, cyc, dbg_state, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] faulted(input logic [WIDTH-1:0] d, input int b,
                                               input logic [1:0] m);
    logic [WIDTH-1:0] mask;
    mask = WIDTH'(1) << b;
    case (m)
      2'b01:   return d & ~mask;
      2'b10:   return d | mask;
      default: return d ^ mask;
    endcase
  endfunction

  // ---------------- reference model + compare ----------------
  // The model keeps the last accepted request as a schedule (accept cycle,
  // delay, effective duration) and derives every output from cycle windows.
  bit               s_valid = 1'b0;
  int               s_t, s_d, s_u, s_bit;
  logic [1:0]       s_mode;
  int               exp_count = 0;
  logic [WIDTH-1:0] exp_dout_next = '0;
  bit               rst_prev = 1'b1;

  always @(negedge clk) begin
    bit rst_now, in_w, in_i, busy, dn;
    logic [WIDTH-1:0] exp_dout;
    rst_now = reset;
    if (rst_now) begin
      s_valid   = 1'b0;
      exp_count = 0;
    end
    in_w = s_valid && (cyc >= s_t + 1) && (cyc <= s_t + s_d);
    in_i = s_valid && (cyc >= s_t + s_d + 1) && (cyc <= s_t + s_d + s_u);
    busy = in_w || in_i;
    dn   = s_valid && (cyc == s_t + s_d + s_u + 1);
    if (dn && STATS && exp_count < 65535) exp_count++;
    exp_dout = (rst_now || rst_prev) ? '0 : exp_dout_next;

    check("mon_dout",   dout,      exp_dout);
    check("mon_active", active,    in_i);
    check("mon_done",   done,      dn);
    check("mon_ready",  req_ready, !busy);
    check("mon_count",  inj_count, exp_count[15:0]);

    // advance to the next cycle
    exp_dout_next = (in_i && !abort) ? faulted(din, s_bit, s_mode) : din;
    if (busy && abort) begin
      s_valid = 1'b0;
    end else if (!busy && req_valid && !rst_now) begin
      s_valid = 1'b1;
      s_t     = cyc;
      s_d     = int'(req_delay);
      s_u     = (req_dur == '0) ? 1 : int'(req_dur);
      s_bit   = int'(req_bit);
      s_mode  = req_mode;
    end
    rst_prev = rst_now;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    din = din_rand ? WIDTH'($urandom) : din_const;
  endtask

  task automatic send(input int b, input int m, input int d, input int u, output int t);
    int guard;
    guard = 0;
    while (!req_ready && guard < 1000) begin
      tick();
      guard++;
    end
    check("send_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_bit   = BW'(b);
    req_mode  = 2'(m);
    req_delay = CNT_W'(d);
    req_dur   = CNT_W'(u);
    t = cyc;
    tick();
    req_valid = 1'b0;
    req_bit   = BW'($urandom);
    req_mode  = 2'($urandom);
    req_delay = CNT_W'($urandom);
    req_dur   = CNT_W'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t, t2, first_act, cnt_before, guard;
    reset = 1'b0; req_valid = 1'b0; req_bit = '0; req_mode = 2'b00;
    req_delay = '0; req_dur = '0; abort = 1'b0; din = '0;
    #1 reset = 1'b1;
    #2;
    check("rst_dout_async", dout, 8'h00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_dout", dout, 8'h00);

    // flip bit 0, delay 0, dur 1, din A5: A4 only two cycles after acceptance
    din_rand = 1'b0; din_const = 8'hA5; tick();
    send(0, 0, 0, 1, t);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("flip_dout", dout, (k == 2) ? 8'hA4 : 8'hA5);
      check("flip_done", done, k == 2);
      tick();
    end

    // stuck-at-1 bit 6, delay 3, dur 4, din 00
    din_const = 8'h00; tick();
    send(6, 2, 3, 4, t);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("sa1_dout",   dout,   (k >= 5 && k <= 8) ? 8'h40 : 8'h00);
      check("sa1_active", active, k >= 4 && k <= 7);
      check("sa1_done",   done,   k == 8);
      tick();
    end

    // dur 0 behaves as dur 1
    din_const = 8'hFF; tick();
    send(3, 0, 0, 0, t);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("dur0_dout",   dout,   (k == 2) ? 8'hF7 : 8'hFF);
      check("dur0_active", active, k == 1);
      check("dur0_done",   done,   k == 2);
      tick();
    end

    // maximum delay: injection starts 256 cycles after acceptance
    send(0, 1, 255, 1, t);
    first_act = -1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      if (active && first_act < 0) first_act = k;
      if (k == 257) begin
        check("dmax_dout", dout, 8'hFE);
        check("dmax_done", done, 1'b1);
      end
      tick();
    end
    check("dmax_start", first_act, 256);

    // abort in the second of four INJECT cycles
    din_const = 8'h00; tick();
    cnt_before = exp_count;
    send(1, 0, 0, 4, t);
    @(negedge clk);
    check("abort_act1", active, 1'b1);
    tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_dout2", dout, 8'h02);
    check("abort_act2", active, 1'b1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_dout3", dout, 8'h00);
    check("abort_act3", active, 1'b0);
    check("abort_ready3", req_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("abort_nodone", done, 1'b0);
      tick();
      @(negedge clk);
    end
    check("abort_count", inj_count, cnt_before[15:0]);
    tick();

    // reset during INJECT: stuck-at-1 bit 0 on 3C
    din_const = 8'h3C; tick();
    send(0, 2, 1, 5, t);
    tick(); tick();
    @(negedge clk);
    check("rinj_dout_pre", dout, 8'h3D);
    check("rinj_act_pre", active, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rinj_dout_async", dout, 8'h00);
    check("rinj_act_async", active, 1'b0);
    check("rinj_done_async", done, 1'b0);
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rinj_ready", req_ready, 1'b1);
      check("rinj_nodone", done, 1'b0);
      tick();
    end

    // back-to-back: second request accepted in the done cycle of the first
    din_rand = 1'b1;
    send(4, 0, 0, 2, t);
    send(5, 1, 1, 1, t2);
    check("b2b_accept_cycle", t2 - t, 3);
    repeat (6) tick();
    @(negedge clk);
    check("b2b_count", inj_count, STATS ? 32'd2 : 32'd0);
    tick();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_bit   = BW'($urandom_range(0, WIDTH - 1));
      req_mode  = 2'($urandom_range(0, 3));
      req_delay = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
      req_dur   = CNT_W'($urandom_range(0, 5));
      abort     = ($urandom_range(0, 11) == 0);
      tick();
    end
    req_valid = 1'b0;
    abort     = 1'b0;
    guard = 0;
    while (!req_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("final_idle", req_ready, 1'b1);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
